// File: rtl/apb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_pkg : shared APB widths, state encoding, request record, alignment check
// Revision: 1.0
// ----------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;
  localparam int ALIGNBITS  = $clog2(STRB_WIDTH);

  localparam int DEFAULT_NUM_REQ        = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_req_t;

  // Word alignment: the low ALIGNBITS address bits must be zero.
  function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
    return ((addr & ADDR_WIDTH'((1 << ALIGNBITS) - 1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_rr_arbiter : rotating-priority encoder with a pointer that moves past
//                  each accepted winner
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   valid,
  input  logic                 enable,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 accept
);

  logic [IDX_WIDTH-1:0] r_ptr;
  logic [IDX_WIDTH-1:0] w_cand;
  logic [IDX_WIDTH-1:0] w_idx;
  logic                 w_found;

  // Search upward from the pointer with wrap; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  always_comb begin
    grant        = '0;
    grant[w_idx] = enable & w_found;
  end

  assign accept    = enable & w_found;
  assign grant_idx = w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (accept) begin
      r_ptr <= (w_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + IDX_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_requester_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_requester_arbiter : shares one APB completer among NUM_REQ requesters
//                         with round-robin arbitration and wait-state timeout
// Revision: 1.0
// ----------------------------------------------------------------------------
module apb_requester_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]    req_strb,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY,
  input  logic                             PSLVERR
);

  localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_t           r_state;
  apb_state_t           w_next_state;
  apb_req_t             r_req;
  apb_req_t             w_sel_req;
  logic [IDX_WIDTH-1:0] r_owner;
  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic [IDX_WIDTH-1:0] w_grant_idx;
  logic                 w_accept;
  logic                 w_sel_aligned;
  logic                 w_timeout;
  logic                 w_done;
  logic                 w_done_err;
  logic [DATA_WIDTH-1:0] w_done_rdata;
  logic                 w_psel;

  apb_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_arb (
    .clk       (PCLK),
    .rst       (PRESET),
    .valid     (req_valid),
    .enable    (r_state == IDLE),
    .grant     (req_ready),
    .grant_idx (w_grant_idx),
    .accept    (w_accept)
  );

  always_comb begin
    w_sel_req.addr  = req_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    w_sel_req.write = req_write[w_grant_idx];
    w_sel_req.wdata = req_wdata[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    w_sel_req.strb  = req_strb[int'(w_grant_idx)*STRB_WIDTH +: STRB_WIDTH];
  end

  assign w_sel_aligned = validAlign(w_sel_req.addr);

  // Fires on the TIMEOUT_CYCLES-th consecutive ACCESS cycle with PREADY low.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ACCESS) && !PREADY &&
                     (r_wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    w_done_err   = 1'b0;
    w_done_rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = w_sel_aligned ? SETUP : ERROR;
        end
      end
      SETUP: begin
        w_next_state = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
          w_done_err   = PSLVERR;
          w_done_rdata = r_req.write ? '0 : PRDATA;
        end else if (w_timeout) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
          w_done_err   = 1'b1;
        end
      end
      ERROR: begin
        w_next_state = IDLE;
        w_done       = 1'b1;
        w_done_err   = 1'b1;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Misaligned requests never touch r_req so the bus keeps its last values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_req      <= '0;
      r_owner    <= '0;
      r_wait_cnt <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (w_accept) begin
        r_owner <= w_grant_idx;
        if (w_sel_aligned) begin
          r_req <= w_sel_req;
        end
      end
      if (r_state == ACCESS && !PREADY) begin
        r_wait_cnt <= r_wait_cnt + CNT_WIDTH'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_done) begin
        rsp_valid[r_owner] <= 1'b1;
        rsp_rdata          <= w_done_rdata;
        rsp_err            <= w_done_err;
      end
    end
  end

  assign w_psel  = (r_state == SETUP) || (r_state == ACCESS);
  assign PSEL    = w_psel;
  assign PENABLE = (r_state == ACCESS);
  assign PWRITE  = r_req.write;
  assign PADDR   = r_req.addr;
  assign PWDATA  = r_req.wdata;
  assign PSTRB   = (w_psel && r_req.write) ? r_req.strb : '0;

endmodule
`default_nettype wire

// File: doc/apb_requester_arbiter.md
Name: apb_requester_arbiter

Overview:
- APB requester-side controller. Shares one APB completer port between NUM_REQ local requesters using round-robin arbitration.
- Sequences each granted request through the apb_pkg state machine: IDLE, SETUP, ACCESS, ERROR.
- Rejects misaligned addresses locally via apb_pkg::validAlign, without any bus activity.
- Aborts stalled transfers with a wait-state timeout.
- Sits between CPU/DMA-style requesters and the APB peripheral register block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort. 0 disables the timeout.
- ADDR_WIDTH, DATA_WIDTH and STRB_WIDTH come from apb_pkg (16/32/4).

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- req_addr  in  NUM_REQ*ADDR_WIDTH  byte address; slice i belongs to requester i.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
- req_strb  in  NUM_REQ*STRB_WIDTH  byte strobes.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  STRB_WIDTH  APB strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB completer response.

Behaviour:
- Reset values on the first edge with PRESET=1:
  - state=IDLE, rr pointer=0, wait counter=0.
  - PSEL/PENABLE/PWRITE=0; PADDR/PWDATA/PSTRB=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Reset mid-transfer drops PSEL with no rsp_valid issued; the requester must reissue.
- Handshake:
  - A request transfers on req_valid[i] & req_ready[i].
  - req_ready is combinational and is asserted only in IDLE, for the winner only.
  - A requester holds its valid and fields stable until accepted.
- Arbitration:
  - The first requester with valid set wins, searching from the rr pointer upward with wrap.
  - On acceptance the pointer becomes winner+1, wrapping at NUM_REQ.
  - If all requesters are valid at pointer=0: 0, 1, 0, 1... (NUM_REQ=2).
- On accept, the request is latched. Next state is SETUP if aligned, ERROR if validAlign fails.
- SETUP (1 cycle):
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE, PWDATA from the latched request.
  - PSTRB = latched strobes on write, all zero on read.
  - Next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all address, control and data outputs stable.
  - PREADY=1: capture PRDATA (reads; 0 on writes) and PSLVERR; next state IDLE.
  - PREADY=0: wait counter increments.
  - Counter reaching TIMEOUT_CYCLES (nonzero): abort, rsp_err=1, rsp_rdata=0, next state IDLE.
- ERROR (1 cycle): PSEL=0, no bus transfer; next state IDLE with rsp_err=1, rsp_rdata=0.
- Response timing:
  - rsp_valid[owner] is registered and pulses for exactly one cycle, the first IDLE cycle after completion.
  - A new accept may occur in that same cycle.
- Latency:
  - Accept at cycle T, SETUP T+1, ACCESS T+2; zero-wait rsp_valid at T+3. Minimum 3 cycles per transfer.
  - Misaligned: ERROR T+1, rsp_valid T+2.
- No back-to-back ACCESS->SETUP; IDLE is always visited between transfers.
- PSEL deasserted: PADDR/PWRITE/PWDATA hold their last values, PENABLE=0, PSTRB=0.
- PSLVERR is sampled only when PSEL&PENABLE&PREADY; PRDATA is ignored otherwise.

Decomposition:
- apb_pkg already supplies the state enum, widths, ALIGNBITS and validAlign.
- Add to apb_pkg:
  - TIMEOUT_CYCLES default constant.
  - NUM_REQ default constant.
  - A packed struct apb_req_t {addr, write, wdata, strb} for the latched request.
- One sub-module: apb_rr_arbiter.
  - Holds the NUM_REQ-wide rotating priority encoder plus pointer register.
  - Outputs grant one-hot and grant index.
  - Pointer advances on accept.

Test Plan:
- Single read, req 0, addr 0x0010, PREADY=1 in ACCESS, PRDATA=0xDEADBEEF: req_ready[0] at T; PSEL at T+1; PENABLE at T+2; rsp_valid[0] at T+3 with rdata 0xDEADBEEF, err 0. PSTRB=0 throughout.
- Write with wait states, req 1, addr 0x0004, wdata 0x12345678, strb 0x3, PREADY low 3 cycles: PADDR/PWDATA/PSTRB stable 4 ACCESS cycles; rsp_valid[1] err 0.
- Both requesters valid continuously, 4 transfers: grants 0, 1, 0, 1. req_ready never two-hot.
- Misaligned addr 0x0006: no PSEL ever; rsp_valid at T+2 with err=1, rdata=0.
- Timeout, TIMEOUT_CYCLES=16, PREADY held low: PSEL drops after 16 ACCESS cycles; rsp_err=1.
- PSLVERR=1 with PREADY: err=1 returned. PRESET asserted mid-ACCESS: PSEL=0 next cycle, no rsp_valid, next grant goes to requester 0.
